// File: rtl/seq_detector_if.sv
// seq_detector_if: groups the serial-data handshake and the detector status
// outputs of seq_detector into one bundle.
//   master : drives din, din_valid, clr; observes detect, state, last4,
//            det_count, sat
//   slave  : the detector side (inputs/outputs reversed)
interface seq_detector_if #(
    parameter int CNT_W = 8
);
    logic             din;
    logic             din_valid;
    logic             clr;
    logic             detect;
    logic [2:0]       state;
    logic [3:0]       last4;
    logic [CNT_W-1:0] det_count;
    logic             sat;

    modport master (
        output din, din_valid, clr,
        input  detect, state, last4, det_count, sat
    );

    modport slave (
        input  din, din_valid, clr,
        output detect, state, last4, det_count, sat
    );
endinterface

// File: rtl/seq_detector.sv
// seq_detector: overlapping detector for the serial pattern 1011.
//   clk        : single clock, rising edge
//   rst        : asynchronous active-low reset
//   bus.din        : serial data bit, sampled only when bus.din_valid=1
//   bus.din_valid  : qualifies din on this edge
//   bus.clr        : synchronous clear of det_count and sat
//   bus.detect     : registered one-cycle pulse after the edge entering S_1011
//   bus.state      : current FSM state
//   bus.last4      : last four sampled bits, bit 0 newest
//   bus.det_count  : saturating detection counter
//   bus.sat        : sticky, set when det_count reaches all-ones
//
// state  | meaning
// -------+---------------------------------------------
// S_IDLE | no useful prefix of 1011 seen
// S_1    | "1" seen
// S_10   | "10" seen
// S_101  | "101" seen
// S_1011 | full pattern just completed
module seq_detector #(
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    seq_detector_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_1    = 3'b001,
        S_10   = 3'b010,
        S_101  = 3'b011,
        S_1011 = 3'b100
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q;
    state_t           state_d;
    logic             enter_1011;
    logic             detect_q;
    logic [3:0]       last4_q;
    logic [CNT_W-1:0] count_q;
    logic             sat_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.din_valid) state_d = bus.din ? S_1    : S_IDLE;
            S_1:    if (bus.din_valid) state_d = bus.din ? S_1    : S_10;
            S_10:   if (bus.din_valid) state_d = bus.din ? S_101  : S_IDLE;
            S_101:  if (bus.din_valid) state_d = bus.din ? S_1011 : S_10;
            S_1011: if (bus.din_valid) state_d = bus.din ? S_1    : S_10;
            // Unused encodings recover even when no data is arriving.
            default: state_d = S_IDLE;
        endcase
    end

    // S_1011 never loops on itself, so "next is S_1011 and current is not"
    // is exactly a valid edge completing the pattern; holding in S_1011
    // during a gap therefore never re-fires detect.
    always_comb begin
        enter_1011 = (state_d == S_1011) && (state_q != S_1011);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            detect_q <= 1'b0;
            last4_q  <= 4'b0000;
        end else begin
            detect_q <= enter_1011;
            if (bus.din_valid) begin
                last4_q <= {last4_q[2:0], bus.din};
            end
        end
    end

    // clr wins over a coincident detection; the counter holds at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else if (bus.clr) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else if (enter_1011 && (count_q != CNT_MAX)) begin
            count_q <= count_q + 1'b1;
            if (count_q == CNT_MAX - 1'b1) begin
                sat_q <= 1'b1;
            end
        end
    end

    assign bus.detect    = detect_q;
    assign bus.state     = state_q;
    assign bus.last4     = last4_q;
    assign bus.det_count = count_q;
    assign bus.sat       = sat_q;
endmodule

// File: doc/seq_detector.md
SEQ_DETECTOR -- requirements
Module: seq_detector

Interface
REQ-001 Parameter CNT_W, default 8: width of the detection counter det_count.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low; asserts immediately, deasserts synchronously to clk.
REQ-004 din  input  1  serial data bit (typically q_d of the upstream D flip-flop stage).
REQ-005 din_valid  input  1  din is sampled only on edges where din_valid=1.
REQ-006 clr  input  1  synchronous clear of det_count and sat.
REQ-007 detect  output  1  registered one-cycle pulse on completion of pattern 1011.
REQ-008 state  output  3  current FSM state encoding.
REQ-009 last4  output  4  last four sampled bits, bit 0 newest.
REQ-010 det_count  output  CNT_W  number of detections, saturating.
REQ-011 sat  output  1  sticky flag: det_count has reached all-ones.

Function
REQ-012 FSM SHALL be Moore-style with states S_IDLE=000, S_1=001, S_10=010, S_101=011, S_1011=100; encodings 101-111 unused.
REQ-013 Transitions SHALL occur only on edges with din_valid=1; with din_valid=0 state, last4, det_count and sat SHALL hold.
REQ-014 S_IDLE: din=1 -> S_1, din=0 -> S_IDLE.
REQ-015 S_1: din=1 -> S_1, din=0 -> S_10.
REQ-016 S_10: din=1 -> S_101, din=0 -> S_IDLE.
REQ-017 S_101: din=1 -> S_1011, din=0 -> S_10.
REQ-018 S_1011 (overlap): din=1 -> S_1, din=0 -> S_10.
REQ-019 Unused encodings SHALL return to S_IDLE on the next edge regardless of din_valid.
REQ-020 detect SHALL be 1 for exactly one cycle, in the cycle after the edge that enters S_1011; detect SHALL be 0 on every other cycle, including when the FSM holds in S_1011 with din_valid=0.
REQ-021 last4 SHALL update as {last4[2:0], din} on each valid edge.
REQ-022 det_count SHALL increment by 1 on each edge that enters S_1011, unless det_count equals 2^CNT_W-1, in which case it SHALL hold (no wrap-around).
REQ-023 sat SHALL be set on the edge where det_count becomes 2^CNT_W-1 and SHALL stay set until clr or reset.
REQ-024 clr=1 SHALL force det_count=0 and sat=0 on that edge, taking priority over a simultaneous increment.
REQ-025 clr SHALL NOT affect state, last4 or detect; a detection coinciding with clr still produces the detect pulse.
REQ-026 Latency from the completing din bit sampled to detect=1 SHALL be exactly one clock.

Reset
REQ-027 While rst=0: state=S_IDLE (000), detect=0, last4=0000, det_count=0, sat=0, independent of clk.
REQ-028 Reset asserted mid-pattern (e.g. in S_101) SHALL discard partial progress; the first valid bits after release are evaluated from S_IDLE.
REQ-029 An edge coinciding with rst=0 SHALL NOT change any output from its reset value.

Verification
REQ-030 Reset: drive rst=0 with random din/din_valid/clr -> all outputs at REQ-027 values; release and stream 1,0,1,1 valid -> detect high one cycle after the 4th bit, det_count=1, last4=1011.
REQ-031 Overlap: stream 1,0,1,1,0,1,1 all valid -> two detect pulses (after bits 4 and 7), det_count=2, state=S_1011 at end.
REQ-032 Gaps: stream 1,0,1,1 with din_valid=0 for 3 cycles between each bit -> a single one-cycle detect, state/last4 hold during gaps, detect not extended while holding in S_1011.
REQ-033 Saturation (CNT_W=8): 256 back-to-back patterns -> det_count stops at 255, sat=1 from the 255th detection; 256th detection still pulses detect.
REQ-034 Clear collision: clr=1 on the same edge that completes a pattern with det_count=5 -> det_count=0, sat=0, detect=1 next cycle.
REQ-035 Reset mid-pattern: stream 1,0,1, pulse rst=0 for 2 cycles, then 1 -> no detect, state=S_1, det_count unchanged at 0.
